mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Moore FSM control unit that sequences the MIPS datapath as a multicycle machine.
//  It decodes op/funct held in the instruction register and drives PC, memory, IR,
//  register-file and ALU control, one micro-step per clk.
//  It supports memory wait states via mem_ready and a watchdog trap.
//  It sits between the instruction register/ALU flags and the datapath control inputs.
// PARAMETERS
//  WAIT_MAX         15  max cycles a memory state may wait for mem_ready before TRAP
//  TRAP_ON_ILLEGAL  1   1: unknown op/funct -> TRAP; 0: treated as NOP (DECODE -> FETCH)
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  op           in   6  instr[31:26] from instruction register
//  funct        in   6  instr[5:0] from instruction register
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes current read/write this cycle
//  pcen         out  1  PC write enable
//  iord         out  1  memory address select: 0 = PC, 1 = ALUOut
//  memread      out  1  memory read strobe
//  memwrite     out  1  memory write strobe
//  irwrite      out  1  instruction register load
//  regwrite     out  1  register file write enable
//  regdst       out  1  write register select: 0 = rt, 1 = rd
//  memtoreg     out  1  writeback select: 0 = ALUOut, 1 = memory data
//  alusrca      out  1  ALU A: 0 = PC, 1 = rs
//  alusrcb      out  2  ALU B: 00 = rt, 01 = 4, 10 = signimm, 11 = signimm<<2
//  alucontrol   out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  pcsrc        out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs
//  jr           out  1  asserted in JR state
//  state_o      out  4  current state encoding (debug)
//  trap         out  1  sticky; FSM halted in TRAP
// BEHAVIOUR
//  Reset: while reset=0, state=FETCH and the wait counter is cleared.
//   pcen/memread/memwrite/irwrite/regwrite/trap are forced 0; other outputs are the FETCH decode.
//  Outputs: pure functions of state (plus zero/mem_ready/op where noted); no output registers.
//  States / transitions (encoding in parentheses):
//   FETCH(0): memread, iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00.
//    irwrite=pcen=mem_ready. mem_ready=1 -> DECODE, else stay.
//   DECODE(1): alusrca=0, alusrcb=11, ADD (branch target -> ALUOut). Next state:
//    lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXEC (funct 001000 -> JR);
//    beq 000100 / bne 000101 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP.
//    Otherwise TRAP if TRAP_ON_ILLEGAL, else FETCH.
//   MEMADR(2): alusrca=1, alusrcb=10, ADD. lw -> MEMRD, sw -> MEMWR.
//   MEMRD(3): iord=1, memread. mem_ready -> MEMWB, else stay.
//   MEMWB(4): regwrite, regdst=0, memtoreg=1 -> FETCH.
//   MEMWR(5): iord=1, memwrite. mem_ready -> FETCH, else stay.
//   EXEC(6): alusrca=1, alusrcb=00; funct 100000 ADD, 100010 SUB, 100100 AND,
//    100101 OR, 101010 SLT. Other funct -> TRAP/FETCH per TRAP_ON_ILLEGAL; else -> ALUWB.
//   ALUWB(7): regwrite, regdst=1, memtoreg=0 -> FETCH.
//   BRANCH(8): alusrca=1, alusrcb=00, SUB, pcsrc=01. pcen = beq ? zero : ~zero -> FETCH.
//   ADDIEX(9): alusrca=1, alusrcb=10, ADD -> ADDIWB.
//   ADDIWB(10): regwrite, regdst=0, memtoreg=0 -> FETCH.
//   JUMP(11): pcsrc=10, pcen -> FETCH.
//   JR(12): pcsrc=11, jr=1, pcen -> FETCH.
//   TRAP(13): trap=1, all enables 0; exits only on reset.
//  Latency (mem_ready=1 on first cycle): R-type/addi/sw 4 cycles, lw 5, beq/bne/j/jr 3.
//  Wait counter: clears on entry to FETCH/MEMRD/MEMWR; increments each cycle with mem_ready=0.
//   Reaching WAIT_MAX with mem_ready still 0 -> TRAP. It saturates and never wraps.
//  mem_ready is ignored outside FETCH/MEMRD/MEMWR. memread and memwrite are never both 1.
//  Async reset mid-instruction aborts it: no write enable fires after reset falls, and
//   execution restarts in FETCH when reset rises.
// TESTING
//  Reset held low 2 cycles -> state_o=0, pcen=0, memread=0, trap=0; release -> memread=1 next cycle.
//  add (op 0, funct 100000), mem_ready=1 -> states 0,1,6,7; alucontrol=010 in EXEC;
//   regwrite=1, regdst=1 only in ALUWB.
//  lw with mem_ready low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4; memtoreg=1 in MEMWB.
//  beq zero=1 -> pcen=1, pcsrc=01 in BRANCH; bne zero=1 -> pcen=0.
//  jr (op 0, funct 001000) -> 0,1,12 with jr=1, pcsrc=11. j -> 0,1,11 with pcsrc=10.
//  op 111111 -> TRAP, trap=1 sticky. mem_ready stuck 0 in FETCH -> TRAP after 15 cycles.
//   Reset pulse -> FETCH, trap=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that drives the datapath one micro-step per clock,
// with memory wait states, a wait-state watchdog and a sticky trap state.
module mips_multicycle_ctrl #(
    parameter int WAIT_MAX        = 15,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       jr,
    output logic [3:0] state_o,
    output logic       trap
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] ADDIEX = 4'd9;
    localparam logic [3:0] ADDIWB = 4'd10;
    localparam logic [3:0] JUMP   = 4'd11;
    localparam logic [3:0] JR     = 4'd12;
    localparam logic [3:0] TRAP   = 4'd13;

    localparam logic [3:0] ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? TRAP : FETCH;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [3:0]    state;
    logic [3:0]    next_state;
    logic [CW-1:0] wait_cnt;
    logic          mem_state;
    logic          timeout;
    logic          funct_legal;
    logic [2:0]    funct_alu;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    // The watchdog fires on the WAIT_MAX-th consecutive cycle without mem_ready.
    assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign timeout   = mem_state && !mem_ready && ((int'(wait_cnt) + 1) >= WAIT_MAX);

    always_comb begin
        next_state = state;
        case (state)
            FETCH:  if (mem_ready) next_state = DECODE;
                    else if (timeout) next_state = TRAP;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW:   next_state = MEMADR;
                    OP_RTYPE:       next_state = (funct == FN_JR) ? JR : EXEC;
                    OP_BEQ, OP_BNE: next_state = BRANCH;
                    OP_ADDI:        next_state = ADDIEX;
                    OP_J:           next_state = JUMP;
                    default:        next_state = ILLEGAL_NEXT;
                endcase
            end
            MEMADR: next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) next_state = MEMWB;
                    else if (timeout) next_state = TRAP;
            MEMWR:  if (mem_ready) next_state = FETCH;
                    else if (timeout) next_state = TRAP;
            EXEC:   next_state = funct_legal ? ALUWB : ILLEGAL_NEXT;
            ADDIEX: next_state = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, JR: next_state = FETCH;
            TRAP:   next_state = TRAP;
            default: next_state = TRAP;
        endcase
    end

    // Any state change clears the counter; staying put only happens while waiting on memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready && (wait_cnt != CW'(WAIT_MAX)))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        pcen       = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = ALU_ADD;
        pcsrc      = 2'b00;
        jr         = 1'b0;
        case (state)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXEC: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = (op == OP_BEQ) ? zero : ~zero;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            JR: begin
                pcsrc = 2'b11;
                jr    = 1'b1;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        // Reset is asynchronous, so enables are masked combinationally to stop mid-instruction writes.
        if (!reset) begin
            pcen     = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
        end
    end

    assign trap    = reset && (state == TRAP);
    assign state_o = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed vector table, hand-written corner sequences,
// and randomized instruction streams checked against an instruction-level model.
module tb_mips_multicycle_ctrl;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6;
    localparam int ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11, JRST = 12, TRAPST = 13;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a, FN_JR = 6'h08;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pcen, iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, jr, trap;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pcen(pcen), .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc), .jr(jr),
        .state_o(state_o), .trap(trap)
    );

    typedef struct packed {
        logic pcen, iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [1:0] pcsrc;
        logic jr, trap;
    } out_t;

    out_t act;
    assign act = {pcen, iord, memread, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                  alusrcb, alucontrol, pcsrc, jr, trap};

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       mr;
        int         st;
        logic       pcen;
        logic       regwrite;
        logic       memread;
    } vec_t;

    typedef struct {
        int   st;
        logic mr;
    } cyc_t;

    vec_t vecs[$];
    cyc_t path[$];

    logic [5:0] cls_op    [12] = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_R};
    logic [5:0] cls_funct [12] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'h11, 6'h22, 6'h33, 6'h01, 6'h3f, 6'h15, FN_JR};

    task automatic checkv(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return 3'b010;
            FN_SUB:  return 3'b110;
            FN_AND:  return 3'b000;
            FN_OR:   return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    // Expected output row per state with a care mask; enables, jr and trap are always checked.
    task automatic spec_row(input int st, input logic [5:0] o, input logic [5:0] fn, input logic z,
                            input logic mr, output out_t val, output out_t care);
        val = '0;
        care = '0;
        {care.pcen, care.memread, care.memwrite, care.irwrite, care.regwrite, care.jr, care.trap} = '1;
        case (st)
            FETCH: begin
                val.memread = 1'b1; care.iord = 1'b1; care.alusrca = 1'b1;
                val.alusrcb = 2'b01; care.alusrcb = 2'b11;
                val.alucontrol = 3'b010; care.alucontrol = 3'b111; care.pcsrc = 2'b11;
                val.irwrite = mr; val.pcen = mr;
            end
            DECODE: begin
                care.alusrca = 1'b1; val.alusrcb = 2'b11; care.alusrcb = 2'b11;
                val.alucontrol = 3'b010; care.alucontrol = 3'b111;
            end
            MEMADR, ADDIEX: begin
                val.alusrca = 1'b1; care.alusrca = 1'b1; val.alusrcb = 2'b10; care.alusrcb = 2'b11;
                val.alucontrol = 3'b010; care.alucontrol = 3'b111;
            end
            MEMRD: begin val.iord = 1'b1; care.iord = 1'b1; val.memread = 1'b1; end
            MEMWB: begin
                val.regwrite = 1'b1; care.regdst = 1'b1; val.memtoreg = 1'b1; care.memtoreg = 1'b1;
            end
            MEMWR: begin val.iord = 1'b1; care.iord = 1'b1; val.memwrite = 1'b1; end
            EXEC: begin
                val.alusrca = 1'b1; care.alusrca = 1'b1; care.alusrcb = 2'b11;
                val.alucontrol = alu_of(fn);
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT)
                    care.alucontrol = 3'b111;
            end
            ALUWB: begin
                val.regwrite = 1'b1; val.regdst = 1'b1; care.regdst = 1'b1; care.memtoreg = 1'b1;
            end
            BRANCH: begin
                val.alusrca = 1'b1; care.alusrca = 1'b1; care.alusrcb = 2'b11;
                val.alucontrol = 3'b110; care.alucontrol = 3'b111;
                val.pcsrc = 2'b01; care.pcsrc = 2'b11;
                val.pcen = (o == OP_BEQ) ? z : !z;
            end
            ADDIWB: begin val.regwrite = 1'b1; care.regdst = 1'b1; care.memtoreg = 1'b1; end
            JUMP: begin val.pcsrc = 2'b10; care.pcsrc = 2'b11; val.pcen = 1'b1; end
            JRST: begin val.pcsrc = 2'b11; care.pcsrc = 2'b11; val.jr = 1'b1; val.pcen = 1'b1; end
            TRAPST: val.trap = 1'b1;
            default: ;
        endcase
    endtask

    task automatic check_cycle(input string tag, input int exp_st);
        out_t val, care;
        checkv({tag, " state"}, 32'(state_o), 32'(exp_st));
        spec_row(exp_st, op, funct, zero, mem_ready, val, care);
        vectors++;
        if (((act ^ val) & care) != '0) begin
            miscompares++;
            $display("[TB] FAIL %s outputs: got %h required %h (mask %h)", tag, act & care, val, care);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z, input logic mr,
                        input int exp_st, input string tag);
        op = o; funct = f; zero = z; mem_ready = mr;
        @(negedge clk);
        check_cycle(tag, exp_st);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0; mem_ready = 1'b1;
        #1;
        checkv({tag, " rst state"}, 32'(state_o), 0);
        checkv({tag, " rst pcen"}, 32'(pcen), 0);
        checkv({tag, " rst memread"}, 32'(memread), 0);
        checkv({tag, " rst irwrite"}, 32'(irwrite), 0);
        checkv({tag, " rst trap"}, 32'(trap), 0);
        checkv({tag, " rst alusrcb"}, 32'(alusrcb), 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    function automatic int waitlen();
        if ($urandom_range(0, 9) == 0) return 14;
        return int'($urandom_range(0, 3));
    endfunction

    function automatic void push_wait(input int st, input int w);
        for (int i = 0; i < w; i++) path.push_back('{st, 1'b0});
        path.push_back('{st, 1'b1});
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    initial begin
        reset = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");

        vecs.push_back('{OP_R, FN_ADD, 0, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_R, FN_ADD, 0, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_R, FN_ADD, 0, 1, EXEC, 0, 0, 0});
        vecs.push_back('{OP_R, FN_ADD, 0, 1, ALUWB, 0, 1, 0});
        vecs.push_back('{OP_LW, 6'h00, 0, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_LW, 6'h00, 0, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_LW, 6'h00, 0, 0, MEMADR, 0, 0, 0});
        vecs.push_back('{OP_LW, 6'h00, 0, 0, MEMRD, 0, 0, 1});
        vecs.push_back('{OP_LW, 6'h00, 0, 0, MEMRD, 0, 0, 1});
        vecs.push_back('{OP_LW, 6'h00, 0, 0, MEMRD, 0, 0, 1});
        vecs.push_back('{OP_LW, 6'h00, 0, 1, MEMRD, 0, 0, 1});
        vecs.push_back('{OP_LW, 6'h00, 0, 1, MEMWB, 0, 1, 0});
        vecs.push_back('{OP_BEQ, 6'h00, 1, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_BEQ, 6'h00, 1, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_BEQ, 6'h00, 1, 1, BRANCH, 1, 0, 0});
        vecs.push_back('{OP_BNE, 6'h00, 1, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_BNE, 6'h00, 1, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_BNE, 6'h00, 1, 1, BRANCH, 0, 0, 0});
        vecs.push_back('{OP_R, FN_JR, 0, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_R, FN_JR, 0, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_R, FN_JR, 0, 1, JRST, 1, 0, 0});
        vecs.push_back('{OP_J, 6'h00, 0, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_J, 6'h00, 0, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_J, 6'h00, 0, 1, JUMP, 1, 0, 0});
        vecs.push_back('{OP_SW, 6'h00, 0, 0, FETCH, 0, 0, 1});
        vecs.push_back('{OP_SW, 6'h00, 0, 0, FETCH, 0, 0, 1});
        vecs.push_back('{OP_SW, 6'h00, 0, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_SW, 6'h00, 0, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_SW, 6'h00, 0, 1, MEMADR, 0, 0, 0});
        vecs.push_back('{OP_SW, 6'h00, 0, 0, MEMWR, 0, 0, 0});
        vecs.push_back('{OP_SW, 6'h00, 0, 1, MEMWR, 0, 0, 0});
        vecs.push_back('{OP_ADDI, 6'h00, 0, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_ADDI, 6'h00, 0, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_ADDI, 6'h00, 0, 1, ADDIEX, 0, 0, 0});
        vecs.push_back('{OP_ADDI, 6'h00, 0, 1, ADDIWB, 0, 1, 0});
        vecs.push_back('{OP_BNE, 6'h00, 0, 1, FETCH, 1, 0, 1});
        vecs.push_back('{OP_BNE, 6'h00, 0, 1, DECODE, 0, 0, 0});
        vecs.push_back('{OP_BNE, 6'h00, 0, 1, BRANCH, 1, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero; mem_ready = vecs[i].mr;
            @(negedge clk);
            check_cycle(tag, vecs[i].st);
            checkv({tag, " pcen"}, 32'(pcen), 32'(vecs[i].pcen));
            checkv({tag, " regwrite"}, 32'(regwrite), 32'(vecs[i].regwrite));
            checkv({tag, " memread"}, 32'(memread), 32'(vecs[i].memread));
            @(posedge clk);
            #1;
        end

        // Illegal opcode traps and stays trapped regardless of mem_ready.
        step(6'h3f, 6'h00, 0, 1, FETCH, "illop");
        step(6'h3f, 6'h00, 0, 1, DECODE, "illop");
        for (int i = 0; i < 3; i++) step(6'h3f, 6'h00, 0, rbit(), TRAPST, "illop hold");
        do_reset("illop");

        // Illegal R-type funct traps out of EXEC.
        step(OP_R, 6'h3f, 0, 1, FETCH, "illfn");
        step(OP_R, 6'h3f, 0, 1, DECODE, "illfn");
        step(OP_R, 6'h3f, 0, 1, EXEC, "illfn");
        step(OP_R, 6'h3f, 0, 1, TRAPST, "illfn");
        do_reset("illfn");

        for (int i = 0; i < 15; i++) step(OP_R, FN_ADD, 0, 0, FETCH, "fetch wd");
        step(OP_R, FN_ADD, 0, 0, TRAPST, "fetch wd");
        step(OP_R, FN_ADD, 0, 1, TRAPST, "fetch wd");
        do_reset("fetch wd");

        // Longest legal wait (WAIT_MAX-1 idle cycles) must not trap.
        step(OP_LW, 6'h00, 0, 1, FETCH, "lw14");
        step(OP_LW, 6'h00, 0, 1, DECODE, "lw14");
        step(OP_LW, 6'h00, 0, 1, MEMADR, "lw14");
        for (int i = 0; i < 14; i++) step(OP_LW, 6'h00, 0, 0, MEMRD, "lw14");
        step(OP_LW, 6'h00, 0, 1, MEMRD, "lw14");
        step(OP_LW, 6'h00, 0, 1, MEMWB, "lw14");

        step(OP_SW, 6'h00, 0, 1, FETCH, "sw wd");
        step(OP_SW, 6'h00, 0, 1, DECODE, "sw wd");
        step(OP_SW, 6'h00, 0, 1, MEMADR, "sw wd");
        for (int i = 0; i < 15; i++) step(OP_SW, 6'h00, 0, 0, MEMWR, "sw wd");
        step(OP_SW, 6'h00, 0, 0, TRAPST, "sw wd");
        do_reset("sw wd");

        // Reset dropped in the middle of a writeback cycle.
        step(OP_R, FN_SUB, 0, 1, FETCH, "midrst");
        step(OP_R, FN_SUB, 0, 1, DECODE, "midrst");
        step(OP_R, FN_SUB, 0, 1, EXEC, "midrst");
        #1;
        checkv("midrst pre regwrite", 32'(regwrite), 1);
        reset = 1'b0;
        #1;
        checkv("midrst state", 32'(state_o), 0);
        checkv("midrst regwrite", 32'(regwrite), 0);
        checkv("midrst pcen", 32'(pcen), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        step(OP_R, FN_SUB, 0, 1, FETCH, "midrst");
        step(OP_R, FN_SUB, 0, 1, DECODE, "midrst");

        // Finish the aborted-and-restarted sub, then a random instruction stream.
        step(OP_R, FN_SUB, 0, 1, EXEC, "midrst");
        step(OP_R, FN_SUB, 0, 1, ALUWB, "midrst");

        for (int n = 0; n < 150; n++) begin
            int   cls;
            logic z;
            string tag;
            cls = int'($urandom_range(0, 11));
            z = rbit();
            tag = $sformatf("rand%0d cls%0d", n, cls);
            path.delete();
            push_wait(FETCH, waitlen());
            path.push_back('{DECODE, rbit()});
            case (cls)
                0, 1, 2, 3, 4: begin
                    path.push_back('{EXEC, rbit()});
                    path.push_back('{ALUWB, rbit()});
                end
                5: begin
                    path.push_back('{MEMADR, rbit()});
                    push_wait(MEMRD, waitlen());
                    path.push_back('{MEMWB, rbit()});
                end
                6: begin
                    path.push_back('{MEMADR, rbit()});
                    push_wait(MEMWR, waitlen());
                end
                7, 8: path.push_back('{BRANCH, rbit()});
                9: begin
                    path.push_back('{ADDIEX, rbit()});
                    path.push_back('{ADDIWB, rbit()});
                end
                10: path.push_back('{JUMP, rbit()});
                default: path.push_back('{JRST, rbit()});
            endcase
            foreach (path[k]) step(cls_op[cls], cls_funct[cls], z, path[k].mr, path[k].st, tag);
        end
        step(OP_R, FN_ADD, 0, 1, FETCH, "rand end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
